// File: rtl/demux_30_hs_pkg.sv
// rtl/demux_30_hs_pkg.sv - shared widths, select encodings and ready-mux helper for the 1:2 word demux
package demux_30_hs_pkg;

  localparam int WIDTH_DEF = 30;
  localparam int CNT_W_DEF = 16;

  // Select encodings: s picks the destination slot.
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  // Ready seen by the producer comes only from the slot that is currently selected.
  function automatic logic sel_ready(input logic s, input logic can_load_0, input logic can_load_1);
    return (s == SEL_OUT1) ? can_load_1 : can_load_0;
  endfunction

endpackage

// File: rtl/demux_30_hs_if.sv
// rtl/demux_30_hs_if.sv - producer/consumer handshake bundle for the 1:2 word demux
interface demux_30_hs_if
  import demux_30_hs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             s;
  logic             in_ready;

  logic [WIDTH-1:0] out_0;
  logic             out_0_vld;
  logic             out_0_rdy;

  logic [WIDTH-1:0] out_1;
  logic             out_1_vld;
  logic             out_1_rdy;

  logic [CNT_W-1:0] cnt_0;
  logic [CNT_W-1:0] cnt_1;

  // Demux side: takes the input word and consumer readies, presents slots and counters.
  modport slave (
    input  in_data, in_valid, s, out_0_rdy, out_1_rdy,
    output in_ready, out_0, out_0_vld, out_1, out_1_vld, cnt_0, cnt_1
  );

  // Environment side: the word producer plus both consumers.
  modport master (
    output in_data, in_valid, s, out_0_rdy, out_1_rdy,
    input  in_ready, out_0, out_0_vld, out_1, out_1_vld, cnt_0, cnt_1
  );

endinterface

// File: rtl/demux_30_slot.sv
// rtl/demux_30_slot.sv - one-entry register slice holding a word until its consumer takes it
module demux_30_slot
  import demux_30_hs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             rdy,
  output logic [WIDTH-1:0] q,
  output logic             vld,
  output logic             can_load
);

  // The slot can take a word when empty or when its current word leaves this cycle.
  assign can_load = !vld | rdy;

  // Load wins over drain so a simultaneous drain+load keeps vld high with the new word;
  // a plain drain clears vld but leaves q at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (load) begin
      q   <= d;
      vld <= 1'b1;
    end else if (rdy) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_30_hs.sv
// rtl/demux_30_hs.sv - 1:2 demux steering 30-bit words into two handshaked slots with per-output counters
module demux_30_hs
  import demux_30_hs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  demux_30_hs_if.slave  bus
);

  logic             can_load_0;
  logic             can_load_1;
  logic             accept;
  logic             load_0;
  logic             load_1;
  logic [CNT_W-1:0] cnt_0_q;
  logic [CNT_W-1:0] cnt_1_q;

  // Back-pressure comes only from the selected slot; the other slot never stalls the producer.
  assign bus.in_ready = sel_ready(bus.s, can_load_0, can_load_1);
  assign accept       = bus.in_valid & bus.in_ready;
  assign load_0       = accept & (bus.s == SEL_OUT0);
  assign load_1       = accept & (bus.s == SEL_OUT1);

  demux_30_slot #(.WIDTH(WIDTH)) u_slot_0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_0),
    .d        (bus.in_data),
    .rdy      (bus.out_0_rdy),
    .q        (bus.out_0),
    .vld      (bus.out_0_vld),
    .can_load (can_load_0)
  );

  demux_30_slot #(.WIDTH(WIDTH)) u_slot_1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_1),
    .d        (bus.in_data),
    .rdy      (bus.out_1_rdy),
    .q        (bus.out_1),
    .vld      (bus.out_1_vld),
    .can_load (can_load_1)
  );

  // Per-output accepted-word counters; they wrap silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_0_q <= '0;
      cnt_1_q <= '0;
    end else begin
      if (load_0) cnt_0_q <= cnt_0_q + CNT_W'(1);
      if (load_1) cnt_1_q <= cnt_1_q + CNT_W'(1);
    end
  end

  assign bus.cnt_0 = cnt_0_q;
  assign bus.cnt_1 = cnt_1_q;

endmodule

// File: tb/tb_demux_30_hs.sv
// tb/tb_demux_30_hs.sv - self-checking bench for demux_30_hs against a queue-based reference model
module tb_demux_30_hs;
  import demux_30_hs_pkg::*;

  localparam int W  = 30;
  localparam int CW = 16;
  localparam logic [W-1:0] WMASK = {W{1'b1}};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  demux_30_hs_if #(.WIDTH(W), .CNT_W(CW)) bus_if ();

  demux_30_hs #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: words in flight per output, and accepted totals per output.
  logic [W-1:0] mq0[$];
  logic [W-1:0] mq1[$];
  int unsigned  macc0;
  int unsigned  macc1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
    logic busy;
    logic r;
    busy = bus_if.s ? (mq1.size() != 0) : (mq0.size() != 0);
    r    = bus_if.s ? bus_if.out_1_rdy : bus_if.out_0_rdy;
    return !busy || r;
  endfunction

  task automatic drive(input logic v, input logic sel, input logic [W-1:0] d,
                       input logic r0, input logic r1);
    bus_if.in_valid  = v;
    bus_if.s         = sel;
    bus_if.in_data   = d;
    bus_if.out_0_rdy = r0;
    bus_if.out_1_rdy = r1;
    #1;
  endtask

  task automatic verify();
    chk("out_0_vld", bus_if.out_0_vld, mq0.size() != 0);
    chk("out_1_vld", bus_if.out_1_vld, mq1.size() != 0);
    if (mq0.size() != 0) chk("out_0_data", bus_if.out_0, mq0[0]);
    if (mq1.size() != 0) chk("out_1_data", bus_if.out_1, mq1[0]);
    chk("in_ready", bus_if.in_ready, model_ready());
    chk("cnt_0", bus_if.cnt_0, macc0 % 65536);
    chk("cnt_1", bus_if.cnt_1, macc1 % 65536);
  endtask

  task automatic advance(output logic acc);
    acc = bus_if.in_valid && model_ready();
    if (mq0.size() != 0 && bus_if.out_0_rdy) void'(mq0.pop_front());
    if (mq1.size() != 0 && bus_if.out_1_rdy) void'(mq1.pop_front());
    if (acc) begin
      if (bus_if.s) begin mq1.push_back(bus_if.in_data); macc1++; end
      else          begin mq0.push_back(bus_if.in_data); macc0++; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic v, input logic sel, input logic [W-1:0] d,
                       input logic r0, input logic r1);
    logic a;
    drive(v, sel, d, r0, r1);
    verify();
    advance(a);
  endtask

  // Asynchronous reset asserted mid-cycle; checks values during and after reset.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_0_vld", bus_if.out_0_vld, 0);
    chk("rst_out_1_vld", bus_if.out_1_vld, 0);
    chk("rst_out_0", bus_if.out_0, 0);
    chk("rst_out_1", bus_if.out_1, 0);
    chk("rst_cnt_0", bus_if.cnt_0, 0);
    chk("rst_cnt_1", bus_if.cnt_1, 0);
    chk("rst_in_ready", bus_if.in_ready, 1);
    mq0.delete();
    mq1.delete();
    macc0 = 0;
    macc1 = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", bus_if.in_ready, 1);
    chk("post_rst_out_0_vld", bus_if.out_0_vld, 0);
    chk("post_rst_out_1_vld", bus_if.out_1_vld, 0);
  endtask

  initial begin
    logic a;
    int acc_n;
    int cyc;
    int t0;
    int t1;

    macc0 = 0;
    macc1 = 0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    verify();

    // 1: fill both slots, then reset mid-cycle
    cycle(1'b1, 1'b0, 30'h0ABC_DEF0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 30'h1234_5678, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 30'h0000_0777, 1'b0, 1'b0);
    verify();
    apply_reset();

    // 2: steering
    drive(1'b1, SEL_OUT0, 30'h0000_0001, 1'b1, 1'b1);
    verify();
    advance(a);
    drive(1'b1, SEL_OUT1, 30'h3FFF_FFFF, 1'b1, 1'b1);
    verify();
    chk("t2_out_0", bus_if.out_0, 30'h0000_0001);
    chk("t2_out_0_vld", bus_if.out_0_vld, 1);
    advance(a);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    verify();
    chk("t2_out_1", bus_if.out_1, 30'h3FFF_FFFF);
    chk("t2_out_1_vld", bus_if.out_1_vld, 1);
    chk("t2_cnt_0", bus_if.cnt_0, 1);
    chk("t2_cnt_1", bus_if.cnt_1, 1);
    advance(a);

    // 3: back-pressure on slot 0, switch select to slot 1
    cycle(1'b1, 1'b0, 30'h0000_0AAA, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 30'h0000_0BBB, 1'b0, 1'b0);
    verify();
    chk("t3_blocked_ready", bus_if.in_ready, 0);
    advance(a);
    drive(1'b1, 1'b1, 30'h0000_0BBB, 1'b0, 1'b0);
    verify();
    chk("t3_switched_ready", bus_if.in_ready, 1);
    advance(a);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    verify();
    chk("t3_out_1", bus_if.out_1, 30'h0000_0BBB);
    chk("t3_out_0_held", bus_if.out_0, 30'h0000_0AAA);
    chk("t3_out_0_vld", bus_if.out_0_vld, 1);
    advance(a);

    // 4: simultaneous drain and load on slot 0
    drive(1'b1, 1'b0, 30'h0000_0155, 1'b1, 1'b0);
    verify();
    chk("t4_ready", bus_if.in_ready, 1);
    advance(a);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    verify();
    chk("t4_out_0", bus_if.out_0, 30'h0000_0155);
    chk("t4_out_0_vld", bus_if.out_0_vld, 1);
    advance(a);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // 5: random streaming of 100 words
    apply_reset();
    acc_n = 0;
    cyc   = 0;
    t0    = 0;
    t1    = 0;
    while (acc_n < 100 && cyc < 2000) begin
      drive(($urandom % 4) != 0, $urandom % 2, $urandom & WMASK, $urandom % 2, $urandom % 2);
      verify();
      if (bus_if.in_valid && model_ready()) begin
        if (bus_if.s) t1++;
        else          t0++;
      end
      advance(a);
      if (a) acc_n++;
      cyc++;
    end
    chk("t5_words_accepted", acc_n, 100);
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    verify();
    chk("t5_cnt_0_total", bus_if.cnt_0, t0);
    chk("t5_cnt_1_total", bus_if.cnt_1, t1);
    chk("t5_out_0_empty", bus_if.out_0_vld, 0);
    chk("t5_out_1_empty", bus_if.out_1_vld, 0);
    advance(a);

    // 6: counter wrap on out_1
    apply_reset();
    for (int i = 0; i < 65536; i++) begin
      cycle(1'b1, 1'b1, $urandom & WMASK, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    verify();
    chk("t6_cnt_1_wrapped", bus_if.cnt_1, 0);
    chk("t6_cnt_0_idle", bus_if.cnt_0, 0);
    advance(a);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    verify();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
